spi_target: RTL and testbench

//  SPI target (slave) endpoint: receive side of the SPI link whose SCLK comes from the

---
 rtl/spi_target.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_target.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// spi_target: SPI target endpoint, SPI modes 0-3 selected by cpol/cpha.
// sclk, cs_n and mosi are oversampled on clk_in through SYNC_STAGES flops.
// Words move through two registers:
//   - tx: a one-word hold register with a valid/ready handshake.
//   - rx: rx_data, with a one-cycle rx_valid pulse when a word lands.
// Optional feature macro: SPI_TARGET_OVERRUN_EN. It adds the rx_overrun
// and rx_ack ports and a sticky overrun flag.
module spi_target #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  async_rst_n,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
`ifdef SPI_TARGET_OVERRUN_EN
  output logic                  rx_overrun,
  input  logic                  rx_ack,
`endif
  output logic                  rx_valid
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync;
  logic [SYNC_STAGES-1:0]  cs_sync;
  logic [SYNC_STAGES-1:0]  mosi_sync;
  logic                    sclk_d;
  logic                    cpol_l;
  logic                    cpha_l;
  logic [CW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]   tx_sr;
  logic [DATA_WIDTH-1:0]   rx_sr;
  logic                    skip_shift;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic                    hold_full;

  // First bit of a word on the wire, and the word with that bit removed.
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] drop_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Synchronise the asynchronous pins.
  // sclk_d is the one-cycle-delayed copy used for edge detection.
  always_ff @(posedge clk_in or negedge async_rst_n) begin
    if (!async_rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, mosi_s;
  logic rise, fall, lead, trail, sample_edge, shift_edge;
  logic last_bit, word_done, start, reload, consume, tx_load;
  logic [DATA_WIDTH-1:0] next_word, rx_word;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Leading edge moves away from the idle level. cpha chooses which edge samples.
  assign rise        = sclk_s & ~sclk_d;
  assign fall        = ~sclk_s & sclk_d;
  assign lead        = cpol_l ? fall : rise;
  assign trail       = cpol_l ? rise : fall;
  assign sample_edge = cpha_l ? trail : lead;
  assign shift_edge  = cpha_l ? lead : trail;

  assign rx_word   = MSB_FIRST ? {rx_sr[DATA_WIDTH-2:0], mosi_s}
                               : {mosi_s, rx_sr[DATA_WIDTH-1:1]};
  assign last_bit  = (bit_cnt == CW'(DATA_WIDTH - 1));
  assign word_done = (state == ACTIVE) && sample_edge && last_bit;

  // The hold register is consumed at select entry and at each word boundary,
  // but only while select is still asserted.
  assign start     = (state == IDLE) && !cs_s;
  assign reload    = word_done && !cs_s;
  assign consume   = start || reload;
  assign next_word = hold_full ? hold_data : '0;
  assign tx_ready  = ~hold_full;
  assign tx_load   = tx_valid && tx_ready;

  // Main FSM: transfer control, shift registers and the tx hold register.
  always_ff @(posedge clk_in or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state      <= IDLE;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      skip_shift <= 1'b0;
      cpol_l     <= 1'b0;
      cpha_l     <= 1'b0;
      hold_data  <= '0;
      hold_full  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      // A load can only land when the register is empty.
      // In the same cycle it is consumed as zeros and refilled.
      if (tx_load) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end else if (consume) begin
        hold_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          miso_oe    <= 1'b0;
          bit_cnt    <= '0;
          skip_shift <= 1'b0;
          if (!cs_s) begin
            state   <= ACTIVE;
            miso_oe <= 1'b1;
            cpol_l  <= cpol;
            cpha_l  <= cpha;
            // cpha=0 presents the first bit now; cpha=1 waits for the leading edge.
            if (!cpha) begin
              miso  <= first_bit(next_word);
              tx_sr <= drop_bit(next_word);
            end else begin
              tx_sr <= next_word;
            end
          end
        end

        ACTIVE: begin
          if (sample_edge) begin
            rx_sr <= rx_word;
            if (last_bit) begin
              rx_data  <= rx_word;
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
              if (!cs_s) begin
                // cpha=0 presents the new first bit now.
                // The trailing edge that follows must then not shift.
                if (!cpha_l) begin
                  miso       <= first_bit(next_word);
                  tx_sr      <= drop_bit(next_word);
                  skip_shift <= 1'b1;
                end else begin
                  tx_sr <= next_word;
                end
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (shift_edge && !cs_s) begin
            if (skip_shift) begin
              skip_shift <= 1'b0;
            end else begin
              miso  <= first_bit(tx_sr);
              tx_sr <= drop_bit(tx_sr);
            end
          end

          // Deselect ends the transfer.
          // A word completing in this same cycle has still been delivered above.
          if (cs_s) begin
            state      <= IDLE;
            miso_oe    <= 1'b0;
            bit_cnt    <= '0;
            skip_shift <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_TARGET_OVERRUN_EN
  logic rx_pending;

  // Track unacknowledged words.
  // A completion while one is still pending sets the sticky overrun flag.
  always_ff @(posedge clk_in or negedge async_rst_n) begin
    if (!async_rst_n) begin
      rx_pending <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (word_done) begin
      rx_pending <= 1'b1;
      if (rx_ack)          rx_overrun <= 1'b0;
      else if (rx_pending) rx_overrun <= 1'b1;
    end else if (rx_ack) begin
      rx_pending <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target.
// The bench plays a behavioural SPI master.
// Expected miso words are whatever sat in the hold register at each word start (zero if empty).
// Expected rx words are the words the master shifted out.
`timescale 1ns/1ps
module tb_spi_target;
  localparam int DW   = 8;
  localparam int SS   = 2;
  localparam int HALF = 8;   // sclk half-period in clk_in cycles

  logic          clk_in = 1'b0;
  logic          async_rst_n;
  logic          cpol, cpha, sclk, cs_n, mosi;
  logic          miso, miso_oe;
  logic [DW-1:0] tx_data;
  logic          tx_valid, tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
`ifdef SPI_TARGET_OVERRUN_EN
  logic          rx_overrun, rx_ack;
`endif

  int            checks = 0;
  int            failures = 0;
  int            rx_cnt = 0;
  int            dbl = 0;
  logic [DW-1:0] rx_q[$];
  time           t_samp, t_valid;
  logic          prev_v = 1'b0;

  spi_target #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .MSB_FIRST(1'b1)) dut (
    .clk_in(clk_in), .async_rst_n(async_rst_n), .cpol(cpol), .cpha(cpha),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data),
`ifdef SPI_TARGET_OVERRUN_EN
    .rx_overrun(rx_overrun), .rx_ack(rx_ack),
`endif
    .rx_valid(rx_valid)
  );

  always #5 clk_in = ~clk_in;

  // Record every rx_valid pulse, and count pulses longer than one cycle.
  always @(negedge clk_in) begin
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      rx_cnt++;
      t_valid = $time;
      if (prev_v) dbl++;
    end
    prev_v = rx_valid;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic half();
    repeat (HALF) @(negedge clk_in);
  endtask

  task automatic do_reset();
    async_rst_n = 1'b0; cpol = 0; cpha = 0; sclk = 0; cs_n = 1; mosi = 0;
    tx_data = '0; tx_valid = 0;
`ifdef SPI_TARGET_OVERRUN_EN
    rx_ack = 0;
`endif
    repeat (3) @(negedge clk_in);
  endtask

  task automatic load_hold(input logic [DW-1:0] w);
    int n = 0;
    while (!tx_ready && n < 500) begin @(negedge clk_in); n++; end
    if (!tx_ready) begin
      checks++; failures++;
      $display("FAIL load_hold_timeout tx_ready=%b required=1", tx_ready);
    end else begin
      tx_data = w; tx_valid = 1'b1;
      @(negedge clk_in);
      tx_valid = 1'b0;
    end
  endtask

  task automatic begin_cs();
    sclk = cpol;
    repeat (4) @(negedge clk_in);
    cs_n = 1'b0;
    half();
  endtask

  task automatic end_cs();
    half();
    cs_n = 1'b1;
    repeat (6) @(negedge clk_in);
  endtask

  // One word from the master, MSB first.
  // Fewer than 8 bits leaves the word partial.
  // cs_at_end raises cs_n together with the final sample edge.
  task automatic xfer(input logic [DW-1:0] mo, input int nbits, input bit cs_at_end,
                      output logic [DW-1:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = mo[DW-1-i];
        half();
        sclk = ~cpol;
        mi = {mi[DW-2:0], miso}; t_samp = $time;
        if (cs_at_end && i == nbits-1) cs_n = 1'b1;
        half();
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[DW-1-i];
        half();
        sclk = cpol;
        mi = {mi[DW-2:0], miso}; t_samp = $time;
        if (cs_at_end && i == nbits-1) cs_n = 1'b1;
        half();
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", miso); end
    checks++; if (miso_oe !== 1'b0) begin failures++; $display("FAIL reset_miso_oe got=%b exp=0", miso_oe); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    checks++; if (rx_data !== '0) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    async_rst_n = 1'b1;
    repeat (4) @(negedge clk_in);
    checks++; if (miso_oe !== 1'b0) begin failures++; $display("FAIL idle_miso_oe got=%b exp=0", miso_oe); end
  endtask

  task automatic test_mode0();
    logic [DW-1:0] mi;
    int c0 = rx_cnt;
    cpol = 0; cpha = 0;
    load_hold(8'hA5);
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL m0_hold_full got=%b exp=0", tx_ready); end
    begin_cs();
    checks++; if (miso_oe !== 1'b1) begin failures++; $display("FAIL m0_miso_oe got=%b exp=1", miso_oe); end
    checks++; if (miso !== 1'b1) begin failures++; $display("FAIL m0_first_bit got=%b exp=1", miso); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL m0_hold_freed got=%b exp=1", tx_ready); end
    xfer(8'h3C, 8, 1'b0, mi);
    end_cs();
    checks++; if (mi !== 8'hA5) begin failures++; $display("FAIL m0_miso_word got=%h exp=a5", mi); end
    checks++; if (rx_cnt - c0 != 1) begin failures++; $display("FAIL m0_rx_pulses got=%0d exp=1", rx_cnt - c0); end
    checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL m0_rx_data got=%h exp=3c", rx_data); end
    checks++; if ((t_valid - t_samp) / 10 != SS + 1) begin
      failures++; $display("FAIL m0_rx_latency got=%0d exp=%0d", (t_valid - t_samp) / 10, SS + 1);
    end
    checks++; if (miso_oe !== 1'b0) begin failures++; $display("FAIL m0_oe_release got=%b exp=0", miso_oe); end
  endtask

  task automatic test_modes();
    logic [DW-1:0] mi;
    for (int m = 1; m < 4; m++) begin
      int c0 = rx_cnt;
      cpol = m[1]; cpha = m[0];
      load_hold(8'h5A);
      begin_cs();
      xfer(8'hC3, 8, 1'b0, mi);
      end_cs();
      checks++; if (mi !== 8'h5A) begin failures++; $display("FAIL mode%0d_miso got=%h exp=5a", m, mi); end
      checks++; if (rx_data !== 8'hC3 || rx_cnt - c0 != 1) begin
        failures++; $display("FAIL mode%0d_rx got=%h/%0d exp=c3/1", m, rx_data, rx_cnt - c0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] mi0, mi1;
    int c0 = rx_cnt;
    int d0 = dbl;
    cpol = 0; cpha = 0;
    rx_q.delete();
    load_hold(8'hAA);
    begin_cs();
    load_hold(8'h55);
    xfer(8'h01, 8, 1'b0, mi0);
    xfer(8'h80, 8, 1'b0, mi1);
    end_cs();
    checks++; if (mi0 !== 8'hAA || mi1 !== 8'h55) begin
      failures++; $display("FAIL b2b_miso got=%h,%h exp=aa,55", mi0, mi1);
    end
    checks++; if (rx_cnt - c0 != 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", rx_cnt - c0); end
    checks++; if (rx_q.size() != 2 || rx_q[0] !== 8'h01 || rx_q[1] !== 8'h80) begin
      failures++; $display("FAIL b2b_rx_words got_n=%0d exp=01,80", rx_q.size());
    end
    checks++; if (dbl != d0) begin failures++; $display("FAIL b2b_pulse_width long_pulses=%0d exp=0", dbl - d0); end
  endtask

  task automatic test_abort();
    logic [DW-1:0] mi;
    int c0 = rx_cnt;
    cpol = 0; cpha = 0;
    load_hold(8'h11);
    begin_cs();
    load_hold(8'h22);
    xfer(8'hF0, 5, 1'b0, mi);
    cs_n = 1'b1;
    repeat (SS + 2) @(negedge clk_in);
    checks++; if (miso_oe !== 1'b0) begin failures++; $display("FAIL abort_oe got=%b exp=0", miso_oe); end
    repeat (6) @(negedge clk_in);
    checks++; if (rx_cnt != c0) begin failures++; $display("FAIL abort_no_rx got=%0d exp=0", rx_cnt - c0); end
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL abort_hold_kept got=%b exp=0", tx_ready); end
    begin_cs();
    xfer(8'h96, 8, 1'b0, mi);
    end_cs();
    checks++; if (mi !== 8'h22) begin failures++; $display("FAIL abort_next_miso got=%h exp=22", mi); end
    checks++; if (rx_data !== 8'h96 || rx_cnt - c0 != 1) begin
      failures++; $display("FAIL abort_next_rx got=%h/%0d exp=96/1", rx_data, rx_cnt - c0);
    end
  endtask

  task automatic test_empty_hold();
    logic [DW-1:0] mi;
    cpol = 1; cpha = 1;
    begin_cs();
    xfer(8'h69, 8, 1'b0, mi);
    end_cs();
    checks++; if (mi !== 8'h00) begin failures++; $display("FAIL empty_miso got=%h exp=00", mi); end
    load_hold(8'h3E);
    tx_data = 8'hC1; tx_valid = 1'b1;
    repeat (2) @(negedge clk_in);
    tx_valid = 1'b0;
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL ignored_tx_ready got=%b exp=0", tx_ready); end
    begin_cs();
    xfer(8'h0F, 8, 1'b0, mi);
    end_cs();
    checks++; if (mi !== 8'h3E) begin failures++; $display("FAIL ignored_tx_value got=%h exp=3e", mi); end
  endtask

  task automatic test_coincident();
    logic [DW-1:0] mi;
    for (int m = 0; m < 2; m++) begin
      int c0 = rx_cnt;
      logic [DW-1:0] w = 8'($urandom);
      cpol = 1'b0; cpha = m[0];
      load_hold(8'hB7);
      begin_cs();
      xfer(w, 8, 1'b1, mi);
      repeat (8) @(negedge clk_in);
      checks++; if (rx_cnt - c0 != 1 || rx_data !== w) begin
        failures++; $display("FAIL coincident%0d_rx got=%h/%0d exp=%h/1", m, rx_data, rx_cnt - c0, w);
      end
      checks++; if (miso_oe !== 1'b0) begin failures++; $display("FAIL coincident%0d_oe got=%b exp=0", m, miso_oe); end
      end_cs();
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 6; s++) begin
      logic [DW-1:0] h[3];
      logic [DW-1:0] w[3];
      bit            ld[3];
      logic [DW-1:0] mi;
      logic [DW-1:0] exp_mi;
      int            nw;
      int            c0;
      nw = $urandom_range(1, 3);
      {cpol, cpha} = 2'($urandom_range(0, 3));
      for (int k = 0; k < 3; k++) begin
        h[k] = 8'($urandom); w[k] = 8'($urandom); ld[k] = ($urandom_range(0, 3) != 0);
      end
      c0 = rx_cnt;
      rx_q.delete();
      if (ld[0]) load_hold(h[0]);
      begin_cs();
      for (int k = 0; k < nw; k++) begin
        if (k + 1 < nw && ld[k+1]) load_hold(h[k+1]);
        xfer(w[k], 8, 1'b0, mi);
        exp_mi = ld[k] ? h[k] : 8'h00;
        checks++; if (mi !== exp_mi) begin
          failures++; $display("FAIL rand%0d_w%0d_miso got=%h exp=%h", s, k, mi, exp_mi);
        end
      end
      end_cs();
      checks++; if (rx_cnt - c0 != nw) begin
        failures++; $display("FAIL rand%0d_pulses got=%0d exp=%0d", s, rx_cnt - c0, nw);
      end
      for (int k = 0; k < nw && k < rx_q.size(); k++) begin
        checks++; if (rx_q[k] !== w[k]) begin
          failures++; $display("FAIL rand%0d_rx%0d got=%h exp=%h", s, k, rx_q[k], w[k]);
        end
      end
    end
  endtask

`ifdef SPI_TARGET_OVERRUN_EN
  task automatic test_overrun();
    logic [DW-1:0] mi;
    rx_ack = 1'b1; @(negedge clk_in); rx_ack = 1'b0;
    checks++; if (rx_overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear0 got=%b exp=0", rx_overrun); end
    cpol = 0; cpha = 0;
    begin_cs();
    xfer(8'h12, 8, 1'b0, mi);
    checks++; if (rx_overrun !== 1'b0) begin failures++; $display("FAIL ovr_first got=%b exp=0", rx_overrun); end
    xfer(8'h34, 8, 1'b0, mi);
    end_cs();
    checks++; if (rx_overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", rx_overrun); end
    checks++; if (rx_data !== 8'h34) begin failures++; $display("FAIL ovr_overwrite got=%h exp=34", rx_data); end
    rx_ack = 1'b1; @(negedge clk_in); rx_ack = 1'b0;
    @(negedge clk_in);
    checks++; if (rx_overrun !== 1'b0) begin failures++; $display("FAIL ovr_ack got=%b exp=0", rx_overrun); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [DW-1:0] mi;
    int c0 = rx_cnt;
    cpol = 0; cpha = 0;
    load_hold(8'h77);
    begin_cs();
    load_hold(8'h44);
    xfer(8'hFF, 3, 1'b0, mi);
    async_rst_n = 1'b0;
    @(negedge clk_in);
    checks++; if (miso_oe !== 1'b0 || miso !== 1'b0) begin
      failures++; $display("FAIL rstmid_miso got=%b/%b exp=0/0", miso_oe, miso);
    end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL rstmid_tx_ready got=%b exp=1", tx_ready); end
    checks++; if (rx_data !== '0 || rx_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_rx got=%h/%b exp=00/0", rx_data, rx_valid);
    end
`ifdef SPI_TARGET_OVERRUN_EN
    checks++; if (rx_overrun !== 1'b0) begin failures++; $display("FAIL rstmid_overrun got=%b exp=0", rx_overrun); end
`endif
    cs_n = 1'b1; sclk = cpol;
    repeat (2) @(negedge clk_in);
    async_rst_n = 1'b1;
    repeat (6) @(negedge clk_in);
    checks++; if (rx_cnt != c0 || miso_oe !== 1'b0) begin
      failures++; $display("FAIL rstmid_after got=%0d/%b exp=0/0", rx_cnt - c0, miso_oe);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_abort();
    test_empty_hold();
    test_coincident();
    test_random();
`ifdef SPI_TARGET_OVERRUN_EN
    test_overrun();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
